// File: rtl/block_deinterleaver.sv
// Ping-pong block deinterleaver: undoes a ROWS x COLS transpose interleaver,
// one frame fills while the previous frame drains in natural order.
module block_deinterleaver #(
    parameter int ROWS = 4,
    parameter int COLS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic in_sof,
    input  logic data_i,
    output logic data_o,
    output logic out_valid,
    output logic out_sof,
    output logic sync_err
);

    localparam int N  = ROWS * COLS;
    localparam int AW = $clog2(N);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wcnt_q, wcnt_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [AW-1:0]   rcnt_q, rcnt_d;
    logic            bank_sel_q, bank_sel_d;
    logic [N-1:0]    bank0_q, bank0_d;
    logic [N-1:0]    bank1_q, bank1_d;
    logic            data_o_q, data_o_d;
    logic            out_valid_q, out_valid_d;
    logic            out_sof_q, out_sof_d;
    logic            sync_err_q, sync_err_d;

    logic [AW-1:0]   wr_addr;
    logic            swap;
    logic            drain_bit;
    logic            fill_bit0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            waddr_q     <= '0;
            rcnt_q      <= '0;
            bank_sel_q  <= 1'b0;
            bank0_q     <= '0;
            bank1_q     <= '0;
            data_o_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            row_q       <= row_d;
            col_q       <= col_d;
            waddr_q     <= waddr_d;
            rcnt_q      <= rcnt_d;
            bank_sel_q  <= bank_sel_d;
            bank0_q     <= bank0_d;
            bank1_q     <= bank1_d;
            data_o_q    <= data_o_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            sync_err_q  <= sync_err_d;
        end
    end

    // Fill side: the write address walks down a column (step COLS) and jumps
    // to the top of the next column on row wrap, so no divide is needed.
    always_comb begin
        wcnt_d     = wcnt_q;
        row_d      = row_q;
        col_d      = col_q;
        waddr_d    = waddr_q;
        bank_sel_d = bank_sel_q;
        bank0_d    = bank0_q;
        bank1_d    = bank1_q;
        sync_err_d = 1'b0;
        wr_addr    = '0;
        swap       = 1'b0;
        if (in_valid) begin
            if (in_sof && (wcnt_q != '0)) begin
                // Resync: this bit becomes index 0 of a fresh frame.
                sync_err_d = 1'b1;
                wr_addr    = '0;
                wcnt_d     = AW'(1);
                row_d      = RW'(1);
                col_d      = '0;
                waddr_d    = AW'(COLS);
            end else begin
                wr_addr = waddr_q;
                if (wcnt_q == AW'(N - 1)) begin
                    swap       = 1'b1;
                    wcnt_d     = '0;
                    row_d      = '0;
                    col_d      = '0;
                    waddr_d    = '0;
                    bank_sel_d = ~bank_sel_q;
                end else begin
                    wcnt_d = wcnt_q + AW'(1);
                    if (row_q == RW'(ROWS - 1)) begin
                        row_d   = '0;
                        col_d   = col_q + CW'(1);
                        waddr_d = AW'(col_q) + AW'(1);
                    end else begin
                        row_d   = row_q + RW'(1);
                        waddr_d = waddr_q + AW'(COLS);
                    end
                end
            end
            if (bank_sel_q) bank1_d[wr_addr] = data_i;
            else            bank0_d[wr_addr] = data_i;
        end
    end

    assign drain_bit = bank_sel_q ? bank0_q[rcnt_q] : bank1_q[rcnt_q];
    assign fill_bit0 = bank_sel_q ? bank1_q[0] : bank0_q[0];

    // Drain side: output bit 0 is launched on the swap edge straight from the
    // bank just completed, so the first bit leaves one cycle after the last
    // input bit; the rest follow from the drain bank at rcnt.
    always_comb begin
        state_d     = state_q;
        rcnt_d      = rcnt_q;
        data_o_d    = 1'b0;
        out_valid_d = 1'b0;
        out_sof_d   = 1'b0;
        if (swap) begin
            state_d     = DRAIN;
            rcnt_d      = AW'(1);
            data_o_d    = fill_bit0;
            out_valid_d = 1'b1;
            out_sof_d   = 1'b1;
        end else if (state_q == DRAIN) begin
            data_o_d    = drain_bit;
            out_valid_d = 1'b1;
            if (rcnt_q == AW'(N - 1)) begin
                rcnt_d  = '0;
                state_d = IDLE;
            end else begin
                rcnt_d = rcnt_q + AW'(1);
            end
        end
    end

    assign data_o    = data_o_q;
    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_block_deinterleaver.sv
// Bench for block_deinterleaver: frame-level reference model with per-cycle
// compare on a 4x4 instance, plus a directed 2x8 instance.
module tb_block_deinterleaver;

    localparam int R  = 4;
    localparam int C  = 4;
    localparam int N  = R * C;
    localparam int R2 = 2;
    localparam int C2 = 8;
    localparam int N2 = R2 * C2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic in_valid = 1'b0, in_sof = 1'b0, data_i = 1'b0;
    logic data_o, out_valid, out_sof, sync_err;

    logic i2_valid = 1'b0, i2_sof = 1'b0, i2_data = 1'b0;
    logic o2_data, o2_valid, o2_sof, o2_sync;

    block_deinterleaver #(.ROWS(R), .COLS(C)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .data_i(data_i),
        .data_o(data_o), .out_valid(out_valid), .out_sof(out_sof), .sync_err(sync_err)
    );

    block_deinterleaver #(.ROWS(R2), .COLS(C2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(i2_valid), .in_sof(i2_sof), .data_i(i2_data),
        .data_o(o2_data), .out_valid(o2_valid), .out_sof(o2_sof), .sync_err(o2_sync)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
        end
    endtask

    // Reference model: collect accepted bits per frame, apply the inverse
    // permutation and queue the expected output bits.
    logic exp_q[$];
    logic exp_sof_q[$];
    logic exp_sync = 1'b0;
    int   mk = 0;
    logic ybuf[N];
    logic xm[N];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mk = 0;
            exp_sync = 1'b0;
        end else begin
            exp_sync = 1'b0;
            if (in_valid) begin
                if (in_sof && mk != 0) begin
                    exp_sync = 1'b1;
                    mk = 0;
                end
                ybuf[mk] = data_i;
                mk++;
                if (mk == N) begin
                    for (int k = 0; k < N; k++) xm[(k % R) * C + k / R] = ybuf[k];
                    for (int j = 0; j < N; j++) begin
                        exp_q.push_back(xm[j]);
                        exp_sof_q.push_back(j == 0);
                    end
                    mk = 0;
                end
            end
        end
    end

    logic got_q[$];
    int   sof_cnt  = 0;
    int   sync_cnt = 0;

    always @(negedge clk) begin
        logic e, s;
        if (rst) begin
            exp_q.delete();
            exp_sof_q.delete();
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_sof", out_sof, 0);
            chk("rst_data_o", data_o, 0);
            chk("rst_sync_err", sync_err, 0);
        end else begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                s = exp_sof_q.pop_front();
                chk("out_valid", out_valid, 1);
                chk("out_sof", out_sof, s);
                chk("data_o", data_o, e);
            end else begin
                chk("idle_out_valid", out_valid, 0);
                chk("idle_out_sof", out_sof, 0);
            end
            chk("sync_err", sync_err, exp_sync);
            if (out_valid) got_q.push_back(data_o);
            if (out_sof) sof_cnt++;
            if (sync_err) sync_cnt++;
        end
    end

    logic got2_q[$];
    int   sof2_idx = -1;
    always @(negedge clk) begin
        if (!rst && o2_valid) begin
            if (o2_sof) sof2_idx = got2_q.size();
            got2_q.push_back(o2_data);
        end
    end

    task automatic send(input logic b, input logic s);
        @(negedge clk);
        in_valid = 1'b1;
        in_sof   = s;
        data_i   = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_sof   = 1'b0;
            data_i   = 1'b0;
        end
    endtask

    task automatic wait_drain(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_sof   = 1'b0;
            if (exp_q.size() == 0 && !out_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk({name, "_drain_timeout"}, 0, 1);
    endtask

    function automatic int ones(input int dummy);
        int n = 0;
        for (int i = 0; i < got_q.size(); i++) n += int'(got_q[i]);
        return n + dummy;
    endfunction

    logic x_all[64];
    logic y2[N2];
    logic x2[N2];
    int   errs;

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_data_o", data_o, 0);
        rst = 1'b0;
        idle(2);

        // Single 1 at interleaved k=4 lands at output j=1.
        got_q.delete(); sof_cnt = 0;
        for (int k = 0; k < N; k++) send(k == 4, k == 0);
        idle(1);
        wait_drain("t1");
        chk("t1_count", got_q.size(), 16);
        if (got_q.size() == 16) chk("t1_bit1", got_q[1], 1);
        chk("t1_ones", ones(0), 1);
        chk("t1_sof", sof_cnt, 1);

        // k=9 with two idle cycles after every bit; output j=6.
        got_q.delete(); sof_cnt = 0;
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < N; k++) begin
                send(f == 0 && k == 9, k == 0);
                idle(2);
            end
        wait_drain("t2");
        chk("t2_count", got_q.size(), 32);
        if (got_q.size() == 32) chk("t2_bit6", got_q[6], 1);
        chk("t2_ones", ones(0), 1);
        chk("t2_sof", sof_cnt, 2);

        // Round trip of 64 random bits through the interleaver rule.
        got_q.delete(); sof_cnt = 0;
        for (int i = 0; i < 64; i++) x_all[i] = logic'($urandom_range(0, 1));
        for (int f = 0; f < 4; f++)
            for (int k = 0; k < N; k++)
                send(x_all[f * N + (k % R) * C + k / R], k == 0);
        idle(1);
        wait_drain("t3");
        chk("t3_count", got_q.size(), 64);
        errs = 0;
        if (got_q.size() == 64)
            for (int i = 0; i < 64; i++) if (got_q[i] !== x_all[i]) errs++;
        chk("t3_roundtrip_errors", errs, 0);
        chk("t3_sof", sof_cnt, 4);

        // Resync: 5 stray ones, then in_sof starts a frame with k=0 and k=13 set.
        got_q.delete(); sync_cnt = 0;
        for (int k = 0; k < 5; k++) send(1'b1, k == 0);
        for (int k = 0; k < N; k++) send(k == 0 || k == 13, k == 0);
        idle(1);
        wait_drain("t4");
        chk("t4_sync_pulses", sync_cnt, 1);
        chk("t4_count", got_q.size(), 16);
        if (got_q.size() == 16) begin
            chk("t4_bit0", got_q[0], 1);
            chk("t4_bit7", got_q[7], 1);
        end
        chk("t4_ones", ones(0), 2);

        // Reset in the middle of a drain (output j=7 of an all-ones frame).
        for (int k = 0; k < N; k++) send(1'b1, k == 0);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_sof   = 1'b0;
                if (out_sof) begin seen = 1'b1; break; end
            end
            if (!seen) chk("t5_sof_timeout", 0, 1);
        end
        repeat (7) @(negedge clk);
        chk("t5_pre_reset_valid", out_valid, 1);
        #1 rst = 1'b1;
        #1;
        chk("t5_async_out_valid", out_valid, 0);
        chk("t5_async_out_sof", out_sof, 0);
        chk("t5_async_data_o", data_o, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        got_q.delete();
        for (int k = 0; k < N; k++) send(k == 2, 1'b0);
        idle(1);
        wait_drain("t5");
        chk("t5_count", got_q.size(), 16);
        if (got_q.size() == 16) chk("t5_bit8", got_q[8], 1);
        chk("t5_ones", ones(0), 1);

        // 2x8 instance: single 1 at k=3 lands at output j=9.
        got2_q.delete();
        for (int k = 0; k < N2; k++) begin
            y2[k] = (k == 3);
            @(negedge clk);
            i2_valid = 1'b1;
            i2_sof   = (k == 0);
            i2_data  = y2[k];
        end
        @(negedge clk);
        i2_valid = 1'b0;
        i2_sof   = 1'b0;
        i2_data  = 1'b0;
        for (int i = 0; i < 40 && got2_q.size() < N2; i++) @(negedge clk);
        for (int k = 0; k < N2; k++) x2[(k % R2) * C2 + k / R2] = y2[k];
        chk("t6_count", got2_q.size(), N2);
        chk("t6_sof_index", sof2_idx, 0);
        if (got2_q.size() == N2) begin
            chk("t6_bit9", got2_q[9], 1);
            errs = 0;
            for (int j = 0; j < N2; j++) if (got2_q[j] !== x2[j]) errs++;
            chk("t6_model_errors", errs, 0);
        end

        idle(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout at t=%0t", $time);
        $fatal(1);
    end

endmodule
